// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// FSM state encoding, operation codes and the default operand width.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // op[0] selects divide, op[1] selects unsigned (when enabled)
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_DIV   = 2'b01,
        OP_MULTU = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the CPU control unit (master) and the
// HI/LO multiply/divide sequencer (slave).
interface muldiv_seq_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi_we, lo_we, hi_out, lo_out
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi_we, lo_we, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_core.sv
// Iteration datapath: one shift-add multiply step or one restoring divide
// step per enabled cycle on unsigned magnitudes.
// r_acc is the upper half (product high / remainder), r_lo the lower half
// (multiplier shifting out / quotient shifting in).
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_opnd,
    input  logic [WIDTH-1:0] i_init_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_last
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [CW-1:0]    r_count;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_neg;

    // Multiply add and divide trial subtract for the current iteration
    always_comb begin
        w_sum   = r_acc + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_shift = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
        w_diff  = {1'b0, w_shift} - {2'b00, r_opnd};
        w_neg   = w_diff[WIDTH+1];
    end

    // Load operands on accept, then advance one step per enabled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_lo    <= i_init_lo;
            r_opnd  <= i_opnd;
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
            if (i_is_div) begin
                r_acc <= w_neg ? w_shift : w_diff[WIDTH:0];
                r_lo  <= {r_lo[WIDTH-2:0], ~w_neg};
            end else begin
                r_acc <= {1'b0, w_sum[WIDTH:1]};
                r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_hi   = r_acc[WIDTH-1:0];
    assign o_lo   = r_lo;
    assign o_last = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO multiply/divide sequencer: FSM, operand and sign capture, final
// two's-complement correction and the HI/LO write strobes.
// Optional build macro: MULDIV_UNSIGNED_EN enables MULTU/DIVU via op[1];
// without it every operation is signed.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);
    state_t           r_state;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_dvd;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic             r_hi_we;
    logic             r_lo_we;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic               w_signed;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_accept;
    logic               w_b_zero;
    logic               w_last;
    logic               w_run;
    logic [WIDTH-1:0]   w_core_hi;
    logic [WIDTH-1:0]   w_core_lo;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

`ifdef MULDIV_UNSIGNED_EN
    assign w_signed = ~bus.op[1];
`else
    assign w_signed = 1'b1;
`endif

    assign w_is_div = bus.op[0];
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    // The most-negative value maps onto itself, which is its correct
    // unsigned magnitude.
    assign w_a_mag  = w_a_neg ? (~bus.a + 1'b1) : bus.a;
    assign w_b_mag  = w_b_neg ? (~bus.b + 1'b1) : bus.b;
    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_b_zero = (bus.b == '0);
    assign w_run    = (r_state == RUN);

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clock),
        .rst       (reset),
        .i_load    (w_accept),
        .i_en      (w_run),
        .i_is_div  (r_is_div),
        .i_opnd    (w_is_div ? w_b_mag : w_a_mag),
        .i_init_lo (w_is_div ? w_a_mag : w_b_mag),
        .o_hi      (w_core_hi),
        .o_lo      (w_core_lo),
        .o_last    (w_last)
    );

    // Sign correction of the raw magnitude result
    always_comb begin
        w_prod_neg = -{w_core_hi, w_core_lo};
        w_fix_hi   = w_core_hi;
        w_fix_lo   = w_core_lo;
        if (r_is_div) begin
            if (r_neg_res) w_fix_lo = -w_core_lo;
            if (r_neg_dvd) w_fix_hi = -w_core_hi;
        end else if (r_neg_res) begin
            {w_fix_hi, w_fix_lo} = w_prod_neg;
        end
    end

    // Control FSM with registered status, strobes and result
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_dvd  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi_we    <= 1'b0;
            r_lo_we    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done     <= 1'b0;
                    r_div_zero <= 1'b0;
                    r_hi_we    <= 1'b0;
                    r_lo_we    <= 1'b0;
                    if (bus.start) begin
                        r_is_div  <= w_is_div;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_dvd <= w_a_neg;
                        r_busy    <= 1'b1;
                        if (w_is_div && w_b_zero) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_last) r_state <= FIX;
                end
                FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_hi_we <= 1'b1;
                    r_lo_we <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done     <= 1'b0;
                    r_div_zero <= 1'b0;
                    r_hi_we    <= 1'b0;
                    r_lo_we    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi_we    = r_hi_we;
    assign bus.lo_we    = r_lo_we;
    assign bus.hi_out   = r_hi;
    assign bus.lo_out   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver queues the hand-computed
// result and completion cycle of every request; the monitor checks each
// done pulse against the head of the queue.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_seq_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        logic         we;
        int           cyc;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'(bus.done), 64'd0);
            end else begin
                e = q.pop_front();
                chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                chk({e.name, "_hi"}, 64'(bus.hi_out), 64'(e.hi));
                chk({e.name, "_lo"}, 64'(bus.lo_out), 64'(e.lo));
                chk({e.name, "_div_zero"}, 64'(bus.div_zero), 64'(e.dz));
                chk({e.name, "_hi_we"}, 64'(bus.hi_we), 64'(e.we));
                chk({e.name, "_lo_we"}, 64'(bus.lo_we), 64'(e.we));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_at(input int t);
        while (cyc < t) next();
    endtask

    // Pulse start for one cycle; optionally queue the expected result
    task automatic issue(input string name, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic edz, input int lat, input bit push,
                         output int t0);
        exp_t e;
        next();
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        t0        = cyc;
        if (push) begin
            e.name = name;
            e.hi   = ehi;
            e.lo   = elo;
            e.dz   = edz;
            e.we   = ~edz;
            e.cyc  = t0 + lat;
            q.push_back(e);
        end
        next();
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            next();
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        repeat (2) next();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [W-1:0] uhi;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (3) next();
        rst = 1'b0;
        next();

        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_hi_we", 64'(bus.hi_we), 64'd0);
        chk("reset_hi", 64'(bus.hi_out), 64'd0);
        chk("reset_lo", 64'(bus.lo_out), 64'd0);

        // 7 * -3 = -21, with busy window and latency
        issue("mult_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT, 1'b1, t0);
        chk("mult_busy_first", 64'(bus.busy), 64'd1);
        wait_at(t0 + LAT);
        chk("mult_busy_last", 64'(bus.busy), 64'd1);
        next();
        chk("mult_busy_after", 64'(bus.busy), 64'd0);
        chk("mult_done_after", 64'(bus.done), 64'd0);
        chk("mult_we_after", 64'(bus.hi_we), 64'd0);
        drain();

        issue("mult_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'h0000_0000, 1'b0, LAT, 1'b1, t0);
        drain();

        issue("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT, 1'b1, t0);
        drain();

        issue("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0000_0000, 32'h8000_0000, 1'b0, LAT, 1'b1, t0);
        drain();

        // 100 / -7 = -14 remainder 2
        issue("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9,
              32'd2, 32'hFFFF_FFF2, 1'b0, LAT, 1'b1, t0);
        drain();

        // 0x451 / 0x20 = 0x22 remainder 0x11
        issue("div_prior", OP_DIV, 32'h451, 32'h20,
              32'h11, 32'h22, 1'b0, LAT, 1'b1, t0);
        drain();

        issue("div_zero", OP_DIV, 32'd5, 32'd0,
              32'h11, 32'h22, 1'b1, 1, 1'b1, t0);
        chk("divz_busy", 64'(bus.busy), 64'd1);
        next();
        chk("divz_busy_after", 64'(bus.busy), 64'd0);
        drain();

        // Second start while busy must be ignored
        issue("mult_3_4", OP_MULT, 32'd3, 32'd4,
              32'd0, 32'd12, 1'b0, LAT, 1'b1, t0);
        wait_at(t0 + 5);
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        next();
        bus.start = 1'b0;
        drain();
        repeat (40) next();

        // Reset mid-run: no done, outputs cleared
        issue("mult_reset", OP_MULT, 32'd3, 32'd4,
              32'd0, 32'd0, 1'b0, LAT, 1'b0, t0);
        wait_at(t0 + 10);
        rst = 1'b1;
        next();
        chk("rst_run_busy", 64'(bus.busy), 64'd0);
        chk("rst_run_done", 64'(bus.done), 64'd0);
        chk("rst_run_lo", 64'(bus.lo_out), 64'd0);
        rst = 1'b0;
        repeat (40) next();
        chk("rst_run_busy_late", 64'(bus.busy), 64'd0);

`ifdef MULDIV_UNSIGNED_EN
        uhi = 32'h0000_0001;
`else
        uhi = 32'hFFFF_FFFF;
`endif
        issue("multu_m1_2", OP_MULTU, 32'hFFFF_FFFF, 32'd2,
              uhi, 32'hFFFF_FFFE, 1'b0, LAT, 1'b1, t0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
